mul_hilo: RTL and testbench

- Multi-cycle multiply unit wrapped around the team's combinational signed multiplier `mul`.
- Registers the operands and feeds them to `mul`.
- Waits a fixed, parameterised latency so the long multiply path has time to settle, then commits the 2*WIDTH-bit product into architectural HI/LO registers.
- Sits between the execute stage (which issues MULT/MTHI/MTLO) and the MFHI/MFLO read path. Exposes busy/done so the pipeline controller can stall.

---
 rtl/mul_hilo_pkg.sv | 17 +
 rtl/mul.sv | 18 +
 rtl/mul_hilo.sv | 87 ++++++++
 tb/tb_mul_hilo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mul_hilo_pkg.sv
// rtl/mul_hilo_pkg.sv - shared op-codes, FSM state type and counter sizing for mul_hilo
package mul_hilo_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MTHI = 2'b01;
  localparam logic [1:0] OP_MTLO = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // LAT tops out at 15, so LAT-2 always fits in four bits
  localparam int CNT_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mul.sv
// rtl/mul.sv - combinational full-width signed multiplier
module mul #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  // sign-extend to the product width so the low 2*WIDTH bits are the exact signed product
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/mul_hilo.sv
// rtl/mul_hilo.sv - multi-cycle MULT/MTHI/MTLO unit committing into HI/LO registers
module mul_hilo
  import mul_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  if (LAT < 2 || LAT > 15) begin : g_bad_lat
    $error("mul_hilo: LAT must be within 2..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 2);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;

  mul #(.WIDTH(WIDTH)) u_mul (
    .a(op_a),
    .b(op_b),
    .p(prod)
  );

  assign busy = (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT: begin
                op_a  <= a;
                op_b  <= b;
                cnt   <= CNT_LOAD;
                state <= S_BUSY;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          // flush beats the commit even when the counter has already expired
          if (flush) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            hi    <= prod[2*WIDTH-1:WIDTH];
            lo    <= prod[WIDTH-1:0];
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_hilo.sv
// tb/tb_mul_hilo.sv - directed self-checking bench for mul_hilo (WIDTH=32, LAT=3)
module tb_mul_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mul_hilo #(.WIDTH(32), .LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);

    // 1: -3 * 7
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007);
    check("t1_c1_busy", {31'b0, busy}, 32'h1);
    check("t1_c1_done", {31'b0, done}, 32'h0);
    tick();
    check("t1_c2_busy", {31'b0, busy}, 32'h1);
    tick();
    check("t1_c3_done", {31'b0, done}, 32'h1);
    check("t1_c3_busy", {31'b0, busy}, 32'h0);
    check("t1_hi", hi, 32'hFFFFFFFF);
    check("t1_lo", lo, 32'hFFFFFFEB);
    tick();
    check("t1_c4_done", {31'b0, done}, 32'h0);

    // 2: most-negative squared, then back-to-back issue in the done cycle
    issue(2'b00, 32'h80000000, 32'h80000000);
    tick();
    tick();
    check("t2a_done", {31'b0, done}, 32'h1);
    check("t2a_hi", hi, 32'h40000000);
    check("t2a_lo", lo, 32'h00000000);
    issue(2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF);
    check("t2b_c4_busy", {31'b0, busy}, 32'h1);
    check("t2b_c4_done", {31'b0, done}, 32'h0);
    tick();
    tick();
    check("t2b_done", {31'b0, done}, 32'h1);
    check("t2b_hi", hi, 32'hFFFFFFFF);
    check("t2b_lo", lo, 32'h80000001);
    tick();

    // 3: start while busy is ignored, operand changes do not leak in
    issue(2'b00, 32'd5, 32'd6);
    start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0;
    check("t3_c2_busy", {31'b0, busy}, 32'h1);
    check("t3_c2_done", {31'b0, done}, 32'h0);
    tick();
    check("t3_done", {31'b0, done}, 32'h1);
    check("t3_hi", hi, 32'h0);
    check("t3_lo", lo, 32'd30);
    tick();
    check("t3_c4_done", {31'b0, done}, 32'h0);
    check("t3_c4_busy", {31'b0, busy}, 32'h0);

    // 5: MTHI then MTLO
    issue(2'b01, 32'h12345678, 32'hFFFFFFFF);
    check("t5_hi", hi, 32'h12345678);
    check("t5_hi_busy", {31'b0, busy}, 32'h0);
    check("t5_hi_done", {31'b0, done}, 32'h0);
    issue(2'b10, 32'h9ABCDEF0, 32'h0);
    check("t5_lo", lo, 32'h9ABCDEF0);
    check("t5_lo_hi", hi, 32'h12345678);
    check("t5_lo_done", {31'b0, done}, 32'h0);

    // 4: flush in the commit cycle
    issue(2'b00, 32'd5, 32'd6);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_busy", {31'b0, busy}, 32'h0);
    check("t4_done", {31'b0, done}, 32'h0);
    check("t4_hi", hi, 32'h12345678);
    check("t4_lo", lo, 32'h9ABCDEF0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_done_later", {31'b0, done}, 32'h0);
    end
    check("t4_lo_later", lo, 32'h9ABCDEF0);

    // flush one cycle after acceptance, before the counter expires
    issue(2'b00, 32'd7, 32'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_c2_busy", {31'b0, busy}, 32'h0);
    tick();
    check("fl_c3_done", {31'b0, done}, 32'h0);
    check("fl_lo", lo, 32'h9ABCDEF0);

    // flush in IDLE blocks a same-cycle start
    flush = 1'b1;
    issue(2'b00, 32'd2, 32'd2);
    flush = 1'b0;
    check("fl_idle_busy", {31'b0, busy}, 32'h0);
    flush = 1'b1;
    issue(2'b01, 32'hCAFEF00D, 32'd0);
    flush = 1'b0;
    check("fl_idle_mthi", hi, 32'h12345678);

    // MTHI during a busy MULT is ignored
    issue(2'b00, 32'd2, 32'hFFFFFFFD);
    issue(2'b01, 32'hDEADBEEF, 32'd0);
    check("t5b_c2_hi", hi, 32'h12345678);
    tick();
    check("t5b_done", {31'b0, done}, 32'h1);
    check("t5b_hi", hi, 32'hFFFFFFFF);
    check("t5b_lo", lo, 32'hFFFFFFFA);
    tick();
    check("t5b_after_hi", hi, 32'hFFFFFFFF);

    // reserved op is a no-op
    issue(2'b11, 32'h55555555, 32'h55555555);
    check("nop_busy", {31'b0, busy}, 32'h0);
    check("nop_hi", hi, 32'hFFFFFFFF);
    check("nop_lo", lo, 32'hFFFFFFFA);

    // 6: reset mid-operation
    issue(2'b00, 32'd5, 32'd6);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_hi", hi, 32'h0);
    check("t6_lo", lo, 32'h0);
    check("t6_busy", {31'b0, busy}, 32'h0);
    check("t6_done", {31'b0, done}, 32'h0);
    tick();
    check("t6_c4_done", {31'b0, done}, 32'h0);

    // reset with a same-cycle start
    rst = 1'b1;
    issue(2'b00, 32'd3, 32'd3);
    rst = 1'b0;
    check("t6b_busy", {31'b0, busy}, 32'h0);
    tick();
    check("t6b_c2_busy", {31'b0, busy}, 32'h0);
    tick();
    check("t6b_done", {31'b0, done}, 32'h0);
    check("t6b_lo", lo, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
